fsk_tx_sequencer: RTL and testbench
===================================

FSK_TX_SEQUENCER -- requirements
Module: fsk_tx_sequencer

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 2304, mainclk cycles per symbol; this is an integer number of carrier periods for both 288- and 384-division carriers.
REQ-002 SHALL have parameter PREAMBLE_BITS, default 8, count of alternating preamble symbols (range 2..15).
REQ-003 SHALL have port mainclk, input, 1, system clock; all logic on posedge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low.
REQ-005 SHALL have port tx_data, input, 8, payload byte from the requester.
REQ-006 SHALL have port tx_valid, input, 1, requester has a byte.
REQ-007 SHALL have port tx_ready, output, 1, sequencer accepts a byte this cycle.
REQ-008 SHALL have port abort, input, 1, synchronous frame cancel.
REQ-009 SHALL have port carrier_en, output, 1, modulator output enable.
REQ-010 SHALL have port carrier_sel, output, 1, 1 = mark carrier (clk288), 0 = space carrier (clk384).
REQ-011 SHALL have port bit_strobe, output, 1, one-cycle pulse on the first cycle of every symbol.
REQ-012 SHALL have port busy, output, 1, high in any non-IDLE state.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse on the last cycle of the stop symbol.

Function
REQ-014 SHALL implement the states IDLE, PREAMBLE, START, DATA, PARITY and STOP, each symbol lasting exactly BIT_CYCLES cycles.
REQ-015 SHALL drive tx_ready = (state==IDLE) && !abort, combinationally.
REQ-016 SHALL accept a byte on tx_valid && tx_ready, latch tx_data and even parity, and enter PREAMBLE on the next cycle with symbol counter 0 and cycle counter 0.
REQ-017 SHALL hold tx_ready low from acceptance until the cycle after frame_done; tx_data changes while busy SHALL be ignored.
REQ-018 SHALL keep the cycle counter in the range 0..BIT_CYCLES-1, with width ceil(log2(BIT_CYCLES)); it wraps to 0 and advances the symbol/state at BIT_CYCLES-1.
REQ-019 SHALL send PREAMBLE_BITS symbols in PREAMBLE, alternating and starting with mark (1,0,1,0,...).
REQ-020 SHALL send the START symbol as space (0).
REQ-021 SHALL send DATA as 8 symbols, LSB first, 1 = mark.
REQ-022 SHALL send PARITY as one symbol equal to the XOR of the 8 data bits (even parity).
REQ-023 SHALL send STOP as one mark symbol, then go to IDLE; there is no back-to-back chaining, and the next frame needs a new handshake.
REQ-024 SHALL register carrier_sel and carrier_en and hold them constant for the whole symbol; carrier_en = 1 in every non-IDLE state.
REQ-025 SHALL hold carrier_sel = 1 (mark) and carrier_en = 0 in IDLE.
REQ-026 SHALL assert bit_strobe when the cycle counter is 0 in a non-IDLE state, giving exactly PREAMBLE_BITS+11 strobes per frame.
REQ-027 SHALL fix the frame length at (PREAMBLE_BITS+11)*BIT_CYCLES cycles, which is 43776 at the defaults.
REQ-028 SHALL, for a handshake at cycle T, give the first bit_strobe at T+1, frame_done at T+(PREAMBLE_BITS+11)*BIT_CYCLES, and tx_ready high again one cycle after frame_done.
REQ-029 SHALL, when abort is sampled high in a non-IDLE state, go to IDLE on the next cycle with counters cleared, no frame_done and no bit_strobe.
REQ-030 SHALL, when abort coincides with the last cycle of STOP, let abort win: no frame_done pulse.
REQ-031 SHALL, when abort coincides with tx_valid in IDLE, accept no byte and remain in IDLE.

Reset
REQ-032 SHALL, while reset is low, immediately force state IDLE, counters 0, tx_ready low, carrier_en 0, carrier_sel 1, bit_strobe 0, busy 0, frame_done 0, and clear the latched byte.
REQ-033 SHALL, when reset is asserted mid-frame, abandon the frame without frame_done and accept a new handshake on the first clock edge after reset release.

Verification
REQ-034 SHALL cover a default-parameter frame: send 0xA5 -> carrier_sel per symbol = 1,0,1,0,1,0,1,0 | 0 | 1,0,1,0,0,1,0,1 | 0 | 1; 19 bit_strobes; frame_done 43776 cycles after the handshake.
REQ-035 SHALL cover parity: send 0x07 -> parity symbol 1; send 0x00 -> parity symbol 0; each symbol exactly 2304 cycles.
REQ-036 SHALL cover the busy handshake: tx_valid held high with a new byte during a frame -> tx_ready stays 0; the second byte is accepted exactly 1 cycle after frame_done.
REQ-037 SHALL cover abort mid-data: abort at the 3rd DATA symbol -> IDLE next cycle, carrier_en 0, no frame_done; a following frame is correct.
REQ-038 SHALL cover the boundary: abort on the frame_done cycle -> frame_done suppressed; abort together with tx_valid in IDLE -> no acceptance.
REQ-039 SHALL cover async reset mid-preamble: outputs take reset values without waiting for a clock edge; a handshake on the first edge after release starts a full-length frame.

Source files
------------

// File: rtl/fsk_tx_sequencer.sv
// FSK frame sequencer: preamble, start, 8 data bits LSB first, even parity, stop.
// Drives the mark/space carrier select for an external modulator, one symbol per BIT_CYCLES.
module fsk_tx_sequencer #(
  parameter int unsigned BIT_CYCLES    = 2304,
  parameter int unsigned PREAMBLE_BITS = 8
) (
  input  logic       mainclk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       abort,
  output logic       carrier_en,
  output logic       carrier_sel,
  output logic       bit_strobe,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cyc_q;
  logic [3:0]    sym_q;
  logic [7:0]    data_q;
  logic          parity_q;
  logic          last_cyc;

  assign last_cyc   = (cyc_q == CW'(BIT_CYCLES - 1));
  assign busy       = (state_q != StIdle);
  assign tx_ready   = (state_q == StIdle) && !abort && reset;
  assign bit_strobe = busy && (cyc_q == '0);
  // Combinational so that an abort on the final stop cycle can still cancel the pulse.
  assign frame_done = (state_q == StStop) && last_cyc && !abort;

  always_ff @(posedge mainclk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cyc_q       <= '0;
      sym_q       <= '0;
      data_q      <= '0;
      parity_q    <= 1'b0;
      carrier_en  <= 1'b0;
      carrier_sel <= 1'b1;
    end else if (busy && abort) begin
      state_q     <= StIdle;
      cyc_q       <= '0;
      sym_q       <= '0;
      carrier_en  <= 1'b0;
      carrier_sel <= 1'b1;
    end else if (state_q == StIdle) begin
      if (tx_valid && tx_ready) begin
        state_q     <= StPreamble;
        cyc_q       <= '0;
        sym_q       <= '0;
        data_q      <= tx_data;
        parity_q    <= ^tx_data;
        carrier_en  <= 1'b1;
        carrier_sel <= 1'b1;
      end
    end else if (!last_cyc) begin
      cyc_q <= cyc_q + 1'b1;
    end else begin
      cyc_q <= '0;
      // Symbol boundary: load the carrier for the symbol that starts next cycle.
      unique case (state_q)
        StPreamble: begin
          if (sym_q == 4'(PREAMBLE_BITS - 1)) begin
            state_q     <= StStart;
            sym_q       <= '0;
            carrier_sel <= 1'b0;
          end else begin
            sym_q       <= sym_q + 1'b1;
            carrier_sel <= sym_q[0];
          end
        end
        StStart: begin
          state_q     <= StData;
          sym_q       <= '0;
          carrier_sel <= data_q[0];
        end
        StData: begin
          data_q <= data_q >> 1;
          if (sym_q == 4'd7) begin
            state_q     <= StParity;
            sym_q       <= '0;
            carrier_sel <= parity_q;
          end else begin
            sym_q       <= sym_q + 1'b1;
            carrier_sel <= data_q[1];
          end
        end
        StParity: begin
          state_q     <= StStop;
          carrier_sel <= 1'b1;
        end
        StStop: begin
          state_q     <= StIdle;
          sym_q       <= '0;
          carrier_en  <= 1'b0;
          carrier_sel <= 1'b1;
        end
        StIdle: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_tx_sequencer.sv
// Bench for fsk_tx_sequencer: one default-parameter instance for the full-length frame,
// one short-symbol instance for the bulk of the vectors, random frames and corner cases.
module tb_fsk_tx_sequencer;

  localparam int SBC = 6;
  localparam int SPB = 5;
  localparam int DBC = 2304;
  localparam int DPB = 8;

  logic       mainclk = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       abort    = 1'b0;
  logic       use_def  = 1'b0;

  logic s_ready, s_en, s_sel, s_strobe, s_busy, s_done;
  logic d_ready, d_en, d_sel, d_strobe, d_busy, d_done;
  logic o_ready, o_en, o_sel, o_strobe, o_busy, o_done;

  always #5 mainclk = ~mainclk;

  fsk_tx_sequencer #(.BIT_CYCLES(SBC), .PREAMBLE_BITS(SPB)) dut (
    .mainclk    (mainclk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid & ~use_def),
    .tx_ready   (s_ready),
    .abort      (abort & ~use_def),
    .carrier_en (s_en),
    .carrier_sel(s_sel),
    .bit_strobe (s_strobe),
    .busy       (s_busy),
    .frame_done (s_done)
  );

  fsk_tx_sequencer dut_def (
    .mainclk    (mainclk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid & use_def),
    .tx_ready   (d_ready),
    .abort      (abort & use_def),
    .carrier_en (d_en),
    .carrier_sel(d_sel),
    .bit_strobe (d_strobe),
    .busy       (d_busy),
    .frame_done (d_done)
  );

  assign o_ready  = use_def ? d_ready  : s_ready;
  assign o_en     = use_def ? d_en     : s_en;
  assign o_sel    = use_def ? d_sel    : s_sel;
  assign o_strobe = use_def ? d_strobe : s_strobe;
  assign o_busy   = use_def ? d_busy   : s_busy;
  assign o_done   = use_def ? d_done   : s_done;

  int tests = 0;
  int fails = 0;
  int bc = SBC;
  int pb = SPB;
  bit obs_sym[$];
  int n_strobe;
  int done_at;

  typedef struct {
    logic [7:0] data;
    bit         parity;
    int         abort_at;     // cycle index within the frame, 0 = none
    int         exp_strobes;
    int         exp_done;     // cycle index of frame_done, -1 = none
  } vec_t;

  // Packed order: {tx_ready, busy, carrier_en, carrier_sel, bit_strobe, frame_done}
  localparam logic [5:0] IdleOut  = 6'b100100;
  localparam logic [5:0] ResetOut = 6'b000100;

  function automatic logic [5:0] obs();
    return {o_ready, o_busy, o_en, o_sel, o_strobe, o_done};
  endfunction

  // Symbol k of a frame carrying byte d, straight from the frame layout rules.
  function automatic bit sym_of(input logic [7:0] d, input int k);
    if (k < pb) return (k % 2) == 0;
    if (k == pb) return 1'b0;
    if (k <= pb + 8) return d[k - pb - 1];
    if (k == pb + 9) return ^d;
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b required %b (ready,busy,en,sel,strobe,done) at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic handshake(input logic [7:0] d, input string name);
    @(negedge mainclk);
    tx_valid = 1'b1;
    tx_data  = d;
    abort    = 1'b0;
    #1;
    check(name, obs(), IdleOut);
  endtask

  task automatic idle_check(input string name);
    @(negedge mainclk);
    tx_valid = 1'b0;
    abort    = 1'b0;
    #1;
    check(name, obs(), IdleOut);
  endtask

  // Cycles 1..len after a handshake, checked against the frame model every cycle.
  task automatic body(input logic [7:0] d, input int abort_at, input int stop_at,
                      input bit keep_valid, input logic [7:0] alt, input string name);
    int len;
    int k;
    int c;
    logic [5:0] exp;
    len = (pb + 11) * bc;
    obs_sym.delete();
    n_strobe = 0;
    done_at  = -1;
    for (int i = 1; i <= len; i++) begin
      if (stop_at > 0 && i > stop_at) break;
      @(negedge mainclk);
      tx_valid = keep_valid;
      tx_data  = keep_valid ? alt : 8'($urandom);
      abort    = (i == abort_at);
      #1;
      k   = (i - 1) / bc;
      c   = (i - 1) % bc;
      exp = {1'b0, 1'b1, 1'b1, sym_of(d, k), c == 0, (i == len) && (i != abort_at)};
      check(name, obs(), exp);
      if (o_strobe) begin
        n_strobe++;
        obs_sym.push_back(o_sel);
      end
      if (o_done) done_at = i;
      if (i == abort_at) break;
    end
  endtask

  vec_t vecs [8];
  bit   pat [19];
  logic [18:0] got_pat;
  logic [18:0] exp_pat;

  initial begin
    vecs[0] = '{8'h07, 1'b1, 0,  16, 96};
    vecs[1] = '{8'h00, 1'b0, 0,  16, 96};
    vecs[2] = '{8'hA5, 1'b0, 51, 9,  -1};
    vecs[3] = '{8'hFF, 1'b0, 0,  16, 96};
    vecs[4] = '{8'h01, 1'b1, 96, 16, -1};
    vecs[5] = '{8'h80, 1'b1, 0,  16, 96};
    vecs[6] = '{8'h6B, 1'b1, 0,  16, 96};
    vecs[7] = '{8'h3C, 1'b0, 0,  16, 96};
    pat = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};

    #1 reset = 1'b0;
    #1;
    check("reset_state", obs(), ResetOut);
    #10 reset = 1'b1;
    idle_check("idle_after_reset");

    // Full-length frame at default parameters.
    use_def = 1'b1;
    bc = DBC;
    pb = DPB;
    handshake(8'hA5, "def_handshake");
    body(8'hA5, 0, 0, 1'b0, 8'h00, "def_a5");
    check_int("def_strobes", n_strobe, 19);
    check_int("def_done_cycle", done_at, 43776);
    got_pat = '0;
    exp_pat = '0;
    for (int k = 0; k < 19; k++) begin
      exp_pat[k] = pat[k];
      if (k < obs_sym.size()) got_pat[k] = obs_sym[k];
    end
    check_int("def_symbols", int'(got_pat), int'(exp_pat));
    idle_check("def_ready_after");

    use_def = 1'b0;
    bc = SBC;
    pb = SPB;
    for (int v = 0; v < 8; v++) begin
      handshake(vecs[v].data, "vec_handshake");
      body(vecs[v].data, vecs[v].abort_at, 0, 1'b0, 8'h00, "vec_frame");
      check_int("vec_strobes", n_strobe, vecs[v].exp_strobes);
      check_int("vec_done", done_at, vecs[v].exp_done);
      if (vecs[v].abort_at == 0)
        check_int("vec_parity", (obs_sym.size() > SPB + 9) ? int'(obs_sym[SPB + 9]) : -1,
                  int'(vecs[v].parity));
      idle_check("vec_idle_after");
    end

    // abort together with tx_valid in IDLE: no acceptance.
    @(negedge mainclk);
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    abort    = 1'b1;
    #1;
    check("abort_valid_idle", obs(), ResetOut);
    idle_check("abort_valid_not_taken");

    // tx_valid held through a frame; second byte taken one cycle after frame_done.
    handshake(8'h3C, "busy_first");
    body(8'h3C, 0, 0, 1'b1, 8'hC3, "busy_frame1");
    check_int("busy_done1", done_at, (SPB + 11) * SBC);
    handshake(8'hC3, "busy_second_accept");
    body(8'hC3, 0, 0, 1'b0, 8'h00, "busy_frame2");
    idle_check("busy_idle_after");

    for (int r = 0; r < 20; r++) begin
      logic [7:0] d;
      int ab;
      d  = 8'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, (SPB + 11) * SBC)) : 0;
      handshake(d, "rand_handshake");
      body(d, ab, 0, 1'b0, 8'h00, "rand_frame");
      idle_check("rand_idle_after");
    end

    // Asynchronous reset mid-preamble, away from any clock edge.
    handshake(8'h5A, "rst_handshake");
    body(8'h5A, 0, 2 * SBC + 2, 1'b0, 8'h00, "rst_preamble");
    #2 reset = 1'b0;
    #1;
    check("async_reset_out", obs(), ResetOut);
    @(posedge mainclk);
    @(posedge mainclk);
    #2 reset = 1'b1;
    handshake(8'h96, "rst_first_edge");
    body(8'h96, 0, 0, 1'b0, 8'h00, "rst_frame");
    check_int("rst_strobes", n_strobe, SPB + 11);
    check_int("rst_done", done_at, (SPB + 11) * SBC);
    idle_check("rst_idle_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
